if_id_stage: RTL and testbench
==============================

Name: if_id_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.
- Owns the PC and fetches from a variable-latency instruction memory, one outstanding request at a time.
- Buffers a returned word while decode is stalled; discards wrong-path fetches on redirect.
- Presents the instruction, PC, PC+4 and pre-sliced opcode/funct to the decode stage. opcode/funct feed the control decoder.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-low
imem_req  out  1  one-cycle request pulse to instruction memory
imem_addr  out  32  fetch address, valid while imem_req=1; bits [1:0] always 0
imem_rvalid  in  1  one-cycle response strobe; exactly one per request, in order, >=1 cycle after req
imem_rdata  in  32  instruction word, valid with imem_rvalid
id_stall  in  1  decode stall from hazard unit: hold IF/ID contents
redirect  in  1  taken branch/j/jal/jr resolved in ID
redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0)
id_valid  out  1  IF/ID holds a live instruction
id_instr  out  32  IF/ID instruction
id_pc  out  32  address of id_instr
id_pc4  out  32  id_pc+4, modulo 2^32
id_opcode  out  6  id_instr[31:26]
id_funct  out  6  id_instr[5:0]

Behaviour:
- Reset (rst_n=0, async):
  - pc=RESET_PC; state=ISSUE; hold register empty.
  - imem_req=0; id_valid=0; id_instr=0; id_pc=0; id_pc4 is combinational from id_pc (=4 during reset).
  - First imem_req occurs in the first cycle after rst_n rises.
- FSM states: ISSUE, WAIT, HOLD, DROP.
- ISSUE:
  - imem_req=1, imem_addr=pc.
  - Next state WAIT.
  - If redirect: pc<=redirect_pc, next state DROP (this request is wrong-path).
- WAIT, imem_rvalid=1 and no redirect:
  - pc<=pc+4.
  - If IF/ID can accept (id_stall=0 or id_valid=0): load IF/ID, next state ISSUE.
  - Otherwise: capture word and pc in the hold register, next state HOLD.
- WAIT, redirect=1:
  - pc<=redirect_pc.
  - If imem_rvalid in the same cycle: discard the word, next state ISSUE.
  - Otherwise: next state DROP.
- HOLD:
  - When IF/ID can accept: move hold register into IF/ID, next state ISSUE.
  - If redirect: discard hold, pc<=redirect_pc, next state ISSUE.
- DROP:
  - On imem_rvalid: discard the word, next state ISSUE.
  - If redirect: pc<=redirect_pc (latest target wins); remain in DROP unless rvalid arrives the same cycle, which discards the word and goes to ISSUE.
- IF/ID register, priority order:
  - redirect: id_valid<=0.
  - else id_stall && id_valid: hold all fields.
  - else load a new word: id_valid<=1, id_instr<=word, id_pc<=fetch address.
  - else: id_valid<=0 (bubble); other fields are don't-care and may hold.
- redirect and id_stall asserted together: redirect wins and the stall is ignored.
- imem_rvalid in ISSUE or HOLD is a protocol violation: ignore it; no state change.
- Timing:
  - Best case with 1-cycle memory: req at cycle t, rvalid at t+1, id_valid at t+2.
  - Throughput is one instruction per 2 cycles.
- PC increments wrap modulo 2^32.
- No other architectural state.

Test Plan:
1. Reset release, memory latency 1, words A0..A3 at 0x0,0x4,0x8,0xC -> imem_addr sequence 0x0,0x4,0x8,0xC on alternate cycles; id_instr A0..A3 with id_pc 0x0..0xC and id_pc4 0x4..0x10; opcode/funct equal instr[31:26]/[5:0].
2. Latency 3 -> exactly one outstanding req; imem_req pulses every 4 cycles; id_valid=0 bubbles between instructions.
3. id_stall held 5 cycles with A1 live and A2's response arriving during the stall -> IF/ID holds A1; no new req issued; A2 appears in the cycle after the stall drops.
4. Redirect to 0x100 while in WAIT (latency 3) -> next state DROP; the late response is discarded; next imem_addr=0x100; id_valid=0 in the cycle after redirect.
5. Redirect to 0x200 coinciding with imem_rvalid -> the word is not loaded; next imem_addr=0x200. Redirect while in HOLD -> held word discarded; next fetch is 0x200.
6. rst_n pulled low mid-WAIT -> outputs clear immediately; after release, fetch restarts at RESET_PC; a stale rvalid arriving during reset has no effect.

Source files
------------

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_stage
//  Description : Instruction-fetch stage and IF/ID pipeline register of the
//                5-stage MIPS core. Owns the PC, issues one instruction-memory
//                request at a time, and buffers a returned word while decode
//                is stalled. Wrong-path fetches are discarded on redirect.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          core clock
//    rst_n        asynchronous active-low reset
//    imem_req     one-cycle request pulse to instruction memory
//    imem_addr    fetch address (word aligned), valid while imem_req=1
//    imem_rvalid  one-cycle response strobe, one per request, in order
//    imem_rdata   instruction word, valid with imem_rvalid
//    id_stall     hazard-unit stall: hold IF/ID contents
//    redirect     taken control transfer resolved in ID
//    redirect_pc  redirect target (bits [1:0] ignored)
//    id_valid     IF/ID holds a live instruction
//    id_instr     IF/ID instruction
//    id_pc        address of id_instr
//    id_pc4       id_pc + 4 (mod 2^32)
//    id_opcode    id_instr[31:26]
//    id_funct     id_instr[5:0]
// ============================================================================
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [5:0]  id_opcode,
    output logic [5:0]  id_funct
);

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,   // request the word at r_pc this cycle
        S_WAIT  = 2'd1,   // request outstanding, word will be used
        S_HOLD  = 2'd2,   // word returned while decode stalled, parked
        S_DROP  = 2'd3    // request outstanding, word is wrong-path
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc;

    logic [31:0] w_target;
    logic        w_accept;
    logic        w_load_mem;
    logic        w_load_hold;

    // Word alignment is forced here rather than trusting the ID stage.
    assign w_target = redirect_pc & 32'hFFFF_FFFC;

    // IF/ID can take a new word when it is empty or decode is moving.
    assign w_accept = !id_stall || !id_valid;

    assign w_load_mem  = (r_state == S_WAIT) && imem_rvalid && !redirect && w_accept;
    assign w_load_hold = (r_state == S_HOLD) && !redirect && w_accept;

    // The state resets into ISSUE, so the request is masked while reset is
    // held; it then appears in the first cycle after rst_n rises.
    assign imem_req  = (r_state == S_ISSUE) && rst_n;
    assign imem_addr = r_pc;

    // ------------------------------------------------------------------
    // Fetch FSM: PC, state and hold buffer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_ISSUE;
            r_pc         <= RESET_PC;
            r_hold_instr <= 32'h0;
            r_hold_pc    <= 32'h0;
        end else begin
            case (r_state)
                S_ISSUE: begin
                    if (redirect) begin
                        // The request going out now is already wrong-path.
                        r_pc    <= w_target;
                        r_state <= S_DROP;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        r_pc    <= w_target;
                        r_state <= imem_rvalid ? S_ISSUE : S_DROP;
                    end else if (imem_rvalid) begin
                        r_pc <= r_pc + 32'd4;
                        if (w_accept) begin
                            r_state <= S_ISSUE;
                        end else begin
                            r_hold_instr <= imem_rdata;
                            r_hold_pc    <= r_pc;
                            r_state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // A stray rvalid here is a protocol violation and ignored.
                    if (redirect) begin
                        r_pc    <= w_target;
                        r_state <= S_ISSUE;
                    end else if (w_accept) begin
                        r_state <= S_ISSUE;
                    end
                end
                S_DROP: begin
                    // Latest redirect target wins while draining.
                    if (redirect) begin
                        r_pc <= w_target;
                    end
                    if (imem_rvalid) begin
                        r_state <= S_ISSUE;
                    end
                end
                default: r_state <= S_ISSUE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // IF/ID pipeline register. Redirect outranks stall.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid <= 1'b0;
            id_instr <= 32'h0;
            id_pc    <= 32'h0;
        end else if (redirect) begin
            id_valid <= 1'b0;
        end else if (id_stall && id_valid) begin
            id_valid <= id_valid;
        end else if (w_load_mem) begin
            id_valid <= 1'b1;
            id_instr <= imem_rdata;
            id_pc    <= r_pc;
        end else if (w_load_hold) begin
            id_valid <= 1'b1;
            id_instr <= r_hold_instr;
            id_pc    <= r_hold_pc;
        end else begin
            id_valid <= 1'b0;
        end
    end

    assign id_pc4    = id_pc + 32'd4;
    assign id_opcode = id_instr[31:26];
    assign id_funct  = id_instr[5:0];

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_stage
//  Description : Self-checking bench for if_id_stage. A variable-latency
//                memory responder and an IF/ID monitor pop expected fetch
//                addresses and delivered PCs from queues filled by the
//                directed stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;

    always #5 clk = ~clk;

    if_id_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_stall    (id_stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4),
        .id_opcode   (id_opcode),
        .id_funct    (id_funct)
    );

    int n_checks = 0;
    int n_err    = 0;
    int lat      = 1;
    bit gap_chk  = 1'b1;
    int n_deliv  = 0;

    logic [31:0] addr_q[$];   // expected fetch addresses, in issue order
    logic [31:0] id_q[$];     // expected PCs delivered into IF/ID

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:2] ^ 6'h23, a[21:2], a[7:2] ^ 6'h15};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic fail(input string tag);
        n_checks++;
        n_err++;
        $error("FAIL %s: observed no event expected event within bound", tag);
    endtask

    task automatic reset_q(input logic [31:0] base);
        addr_q.delete();
        id_q.delete();
        for (int i = 0; i < 16; i++) begin
            addr_q.push_back(base + 32'(4 * i));
            id_q.push_back(base + 32'(4 * i));
        end
    endtask

    // ------------------------------------------------------------------
    // Memory responder: one outstanding request, fixed latency 'lat'.
    // ------------------------------------------------------------------
    initial begin
        int          cnt;
        int          cyc;
        int          prev_cyc;
        int          prev_lat;
        logic [31:0] paddr;
        cnt = 0; cyc = 0; prev_cyc = -1; prev_lat = 0; paddr = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            imem_rvalid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(paddr);
                end
            end
            if (imem_req === 1'b1) begin
                chk("one_outstanding", 32'(cnt), 32'd0);
                if (addr_q.size() == 0) fail("unexpected_req");
                else chk("imem_addr", imem_addr, addr_q.pop_front());
                if (gap_chk && prev_cyc >= 0)
                    chk("req_gap", 32'(cyc - prev_cyc), 32'(prev_lat + 1));
                prev_cyc = cyc;
                prev_lat = lat;
                paddr    = imem_addr;
                cnt      = lat;
            end
            if (!gap_chk) prev_cyc = -1;
        end
    end

    // ------------------------------------------------------------------
    // IF/ID monitor: each freshly loaded instruction pops one expected PC;
    // a stalled cycle must repeat the previous contents.
    // ------------------------------------------------------------------
    initial begin
        bit          prev_hold;
        logic [31:0] last_pc;
        logic [31:0] last_instr;
        logic [31:0] e;
        logic [31:0] w;
        prev_hold = 1'b0; last_pc = 32'h0; last_instr = 32'h0;
        forever begin
            @(negedge clk);
            if (id_valid === 1'b1) begin
                if (prev_hold) begin
                    chk("hold_pc", id_pc, last_pc);
                    chk("hold_instr", id_instr, last_instr);
                end else if (id_q.size() == 0) begin
                    fail("unexpected_id");
                end else begin
                    e = id_q.pop_front();
                    w = mem_word(e);
                    chk("id_pc", id_pc, e);
                    chk("id_instr", id_instr, w);
                    chk("id_pc4", id_pc4, e + 32'd4);
                    chk("id_opcode", {26'd0, id_opcode}, {26'd0, w[31:26]});
                    chk("id_funct", {26'd0, id_funct}, {26'd0, w[5:0]});
                    n_deliv++;
                    last_pc    = e;
                    last_instr = w;
                end
            end
            #2;
            prev_hold = (id_valid === 1'b1) && id_stall && !redirect && rst_n;
        end
    end

    // Inputs change 1 time unit after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (imem_req === 1'b1) return;
            step();
        end
        fail(tag);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (id_valid === 1'b1) return;
            step();
        end
        fail(tag);
    endtask

    task automatic wait_deliv(input int n, input string tag);
        for (int i = 0; i < 200; i++) begin
            if (n_deliv >= n) return;
            step();
        end
        fail(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        int          bub;
        logic [31:0] x;
        rst_n       = 1'b0;
        id_stall    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        reset_q(32'h0);
        for (int i = 16; i < 32; i++) begin
            addr_q.push_back(32'(4 * i));
            id_q.push_back(32'(4 * i));
        end

        // Reset state
        repeat (3) step();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_pc4", id_pc4, 32'h4);

        // 1: latency 1, sequential fetch every other cycle
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        wait_deliv(4, "t1_deliver");

        // 2: latency 3, request every 4 cycles with 3 bubbles between
        lat = 3;
        wait_deliv(6, "t2_deliver");
        wait_valid("t2_valid");
        bub = 0;
        step();
        while (id_valid !== 1'b1 && bub < 20) begin
            bub++;
            step();
        end
        chk("t2_bubbles", 32'(bub), 32'd3);
        chk("t2_req_with_valid", {31'd0, imem_req}, 32'd1);

        // 3: stall 5 cycles with the next response arriving meanwhile
        gap_chk  = 1'b0;
        x        = 32'(4 * (n_deliv - 1));
        id_stall = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("t3_no_req", {31'd0, imem_req}, 32'd0);
            chk("t3_hold_pc", id_pc, x);
            chk("t3_hold_valid", {31'd0, id_valid}, 32'd1);
            if (k == 5) id_stall = 1'b0;
        end
        step();
        chk("t3_next_pc", id_pc, x + 32'd4);
        chk("t3_next_valid", {31'd0, id_valid}, 32'd1);
        chk("t3_req_resume", {31'd0, imem_req}, 32'd1);

        // 4: redirect during WAIT -> DROP, late word discarded
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        reset_q(32'h100);
        step();
        redirect = 1'b0;
        chk("t4_valid_cleared", {31'd0, id_valid}, 32'd0);
        chk("t4_drop_no_req", {31'd0, imem_req}, 32'd0);
        wait_req("t4_req");
        chk("t4_addr", imem_addr, 32'h100);
        chk("t4_discarded", {31'd0, id_valid}, 32'd0);

        // 5a: redirect coinciding with rvalid, unaligned target
        repeat (3) step();
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        reset_q(32'h200);
        step();
        redirect = 1'b0;
        chk("t5a_req", {31'd0, imem_req}, 32'd1);
        chk("t5a_addr", imem_addr, 32'h200);
        chk("t5a_not_loaded", {31'd0, id_valid}, 32'd0);

        // 5b: redirect while a word is parked in HOLD, stall also high
        wait_valid("t5b_valid");
        chk("t5b_pc", id_pc, 32'h200);
        id_stall = 1'b1;
        repeat (4) step();
        chk("t5b_hold_no_req", {31'd0, imem_req}, 32'd0);
        chk("t5b_hold_pc", id_pc, 32'h200);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        reset_q(32'h200);
        step();
        redirect = 1'b0;
        id_stall = 1'b0;
        chk("t5b_req", {31'd0, imem_req}, 32'd1);
        chk("t5b_addr", imem_addr, 32'h200);
        chk("t5b_valid_cleared", {31'd0, id_valid}, 32'd0);

        // 5c: redirect from ISSUE to the top word; PC wraps to 0
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        reset_q(32'hFFFF_FFFC);
        step();
        redirect = 1'b0;
        chk("t5c_drop_no_req", {31'd0, imem_req}, 32'd0);
        wait_req("t5c_req_top");
        chk("t5c_addr_top", imem_addr, 32'hFFFF_FFFC);
        wait_valid("t5c_valid");
        chk("t5c_pc4_wrap", id_pc4, 32'h0);
        wait_req("t5c_req_wrap");
        chk("t5c_addr_wrap", imem_addr, 32'h0);

        // 6: asynchronous reset in WAIT, stale rvalid during reset
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_req", {31'd0, imem_req}, 32'd0);
        chk("t6_valid", {31'd0, id_valid}, 32'd0);
        chk("t6_instr", id_instr, 32'h0);
        chk("t6_pc", id_pc, 32'h0);
        chk("t6_pc4", id_pc4, 32'h4);
        reset_q(32'h0);
        repeat (5) step();
        chk("t6_held_valid", {31'd0, id_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        chk("t6_restart_req", {31'd0, imem_req}, 32'd1);
        chk("t6_restart_addr", imem_addr, 32'h0);
        wait_valid("t6_valid_after");
        chk("t6_restart_pc", id_pc, 32'h0);

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
